// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: grants the crossbar slave path to one of NUM_MASTERS requesters.
// Round-robin among masters, with a priority master (jtag2axi) that may win at most
// MAX_PRIO_BURST times in a row while others wait. A grant is held until txn_done_i,
// or until a watchdog force-releases it after TIMEOUT_CYCLES cycles.
//
//   state | meaning
//   IDLE  | no grant; arbitrate when any request is present
//   GRANT | grant held; waiting for txn_done_i or watchdog expiry
//   GAP   | one dead cycle with no grant so the crossbar muxes hand over cleanly
//
// The round-robin pointer (last_idx_q) only moves on grants made by the rotating scan.
// Priority-path grants leave it alone, otherwise a busy priority master would keep
// resetting the scan start and the highest-numbered non-priority master would starve.
module axi_master_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int PRIO_MASTER    = 2,
  parameter int MAX_PRIO_BURST = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clock_i,
  input  logic                           reset_ni,
  input  logic [NUM_MASTERS-1:0]         req_i,
  input  logic                           txn_done_i,
  output logic [NUM_MASTERS-1:0]         grant_o,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_idx_o,
  output logic                           grant_valid_o,
  output logic                           timeout_o,
  output logic [7:0]                     timeout_cnt_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = $clog2(MAX_PRIO_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]          grant_idx_q;
  logic                   grant_valid_q;
  logic                   timeout_q;
  logic [7:0]             timeout_cnt_q;
  logic [IW-1:0]          last_idx_q;
  logic [SW-1:0]          prio_streak_q;
  logic [WW-1:0]          wdog_q;

  logic                   others_req_d;
  logic                   prio_win_d;
  logic [IW-1:0]          win_idx_d;
  logic                   scan_found_d;
  logic [IW-1:0]          cand_d;

  // Winner selection: priority master if eligible, else rotating scan after last_idx_q.
  always_comb begin
    others_req_d = |(req_i & ~(NUM_MASTERS'(1) << PRIO_MASTER));
    prio_win_d   = req_i[PRIO_MASTER] &&
                   ((prio_streak_q < SW'(MAX_PRIO_BURST)) || !others_req_d);
    win_idx_d    = IW'(PRIO_MASTER);
    scan_found_d = 1'b0;
    cand_d       = '0;
    if (!prio_win_d) begin
      // The priority master can only reach here when idle or excluded, so always skip it.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        cand_d = IW'((int'(last_idx_q) + k) % NUM_MASTERS);
        if (!scan_found_d && req_i[cand_d] && (cand_d != IW'(PRIO_MASTER))) begin
          win_idx_d    = cand_d;
          scan_found_d = 1'b1;
        end
      end
    end
  end

  // Arbitration FSM with registered grant, watchdog and timeout bookkeeping.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      timeout_cnt_q <= '0;
      last_idx_q    <= IW'(NUM_MASTERS - 1);
      prio_streak_q <= '0;
      wdog_q        <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q       <= GRANT;
            grant_q       <= NUM_MASTERS'(1) << win_idx_d;
            grant_idx_q   <= win_idx_d;
            grant_valid_q <= 1'b1;
            wdog_q        <= '0;
            if (prio_win_d) begin
              if (prio_streak_q != SW'(MAX_PRIO_BURST)) prio_streak_q <= prio_streak_q + SW'(1);
            end else begin
              prio_streak_q <= '0;
              last_idx_q    <= win_idx_d;
            end
          end
        end
        GRANT: begin
          if (txn_done_i) begin
            state_q       <= GAP;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
          end else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
            state_q       <= GAP;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b1;
            if (timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 8'd1;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;
  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: vector table of request patterns with hand-derived
// winners, a scoreboard queue of expected grant indices, and hand-written sequences
// for watchdog expiry, done/timeout collision and mid-grant reset.
module tb_axi_master_arbiter;

  localparam int NM  = 3;
  localparam int TO  = 16;
  localparam int MPB = 4;

  logic          clock_i    = 1'b0;
  logic          reset_ni   = 1'b0;
  logic [NM-1:0] req_i      = '0;
  logic          txn_done_i = 1'b0;
  logic [NM-1:0] grant_o;
  logic [1:0]    grant_idx_o;
  logic          grant_valid_o;
  logic          timeout_o;
  logic [7:0]    timeout_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  typedef struct {
    logic [NM-1:0] req;
    int            hold;
    int            lat;
    int            exp_idx;
  } vec_t;

  vec_t vecs[24];

  axi_master_arbiter #(
    .NUM_MASTERS   (NM),
    .PRIO_MASTER   (2),
    .MAX_PRIO_BURST(MPB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_i      (clock_i),
    .reset_ni     (reset_ni),
    .req_i        (req_i),
    .txn_done_i   (txn_done_i),
    .grant_o      (grant_o),
    .grant_idx_o  (grant_idx_o),
    .grant_valid_o(grant_valid_o),
    .timeout_o    (timeout_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Grant must be zero or one-hot and match the reported index.
  always @(negedge clock_i) begin
    if (reset_ni) begin
      n_cmp++;
      if (grant_valid_o ? (grant_o != (3'b001 << grant_idx_o)) : (grant_o != 3'b000)) begin
        n_bad++;
        $display("FAIL invariant: grant_o=%b idx=%0d valid=%b", grant_o, grant_idx_o, grant_valid_o);
      end
    end
  end

  task automatic wait_grant(input int exp_lat, input string tag);
    int cnt;
    int e;
    cnt = 0;
    do begin
      @(negedge clock_i);
      cnt++;
    end while (!grant_valid_o && cnt < 8);
    check({tag, "_grant_seen"}, int'(grant_valid_o), 1);
    if (!grant_valid_o) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    check({tag, "_latency"}, cnt, exp_lat);
    check({tag, "_sb_nonempty"}, int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_idx"}, int'(grant_idx_o), e);
      check({tag, "_onehot"}, int'(grant_o), 1 << e);
    end
  endtask

  task automatic release_txn(input int hold, input string tag);
    repeat (hold) @(negedge clock_i);
    txn_done_i = 1'b1;
    @(negedge clock_i);
    txn_done_i = 1'b0;
    check({tag, "_released"}, int'(grant_valid_o), 0);
    check({tag, "_no_timeout"}, int'(timeout_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got stuck, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int gc;

    // Test 1: masters 0/1 alternate.
    for (int i = 0; i < 4; i++) vecs[i] = '{3'b011, 2, (i == 0) ? 1 : 2, i % 2};
    // Test 2: all request; priority master capped at 4 in a row, others rotate.
    vecs[4]  = '{3'b111, 1, 2, 2};
    vecs[5]  = '{3'b111, 1, 2, 2};
    vecs[6]  = '{3'b111, 1, 2, 2};
    vecs[7]  = '{3'b111, 1, 2, 2};
    vecs[8]  = '{3'b111, 1, 2, 0};
    vecs[9]  = '{3'b111, 1, 2, 2};
    vecs[10] = '{3'b111, 1, 2, 2};
    vecs[11] = '{3'b111, 1, 2, 2};
    vecs[12] = '{3'b111, 1, 2, 2};
    vecs[13] = '{3'b111, 1, 2, 1};
    // Test 3: priority master alone keeps winning past the streak limit.
    for (int i = 14; i < 24; i++) vecs[i] = '{3'b100, 0, 2, 2};

    // Reset state
    repeat (3) @(negedge clock_i);
    check("rst_valid", int'(grant_valid_o), 0);
    check("rst_grant", int'(grant_o), 0);
    check("rst_idx", int'(grant_idx_o), 0);
    check("rst_timeout", int'(timeout_o), 0);
    check("rst_tcnt", int'(timeout_cnt_o), 0);
    reset_ni = 1'b1;
    @(negedge clock_i);

    for (int i = 0; i < 24; i++) begin
      req_i = vecs[i].req;
      exp_q.push_back(vecs[i].exp_idx);
      wait_grant(vecs[i].lat, $sformatf("v%0d", i));
      release_txn(vecs[i].hold, $sformatf("v%0d", i));
    end
    req_i = '0;
    repeat (4) begin
      @(negedge clock_i);
      check("idle_no_grant", int'(grant_valid_o), 0);
    end

    // Test 4: master 1 never completes; requester also drops req mid-grant.
    req_i = 3'b010;
    exp_q.push_back(1);
    wait_grant(1, "to");
    gc = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock_i);
      if (!grant_valid_o) break;
      gc++;
      if (gc == 3) req_i = '0;
    end
    check("to_hold_cycles", gc, TO);
    check("to_pulse", int'(timeout_o), 1);
    check("to_cnt", int'(timeout_cnt_o), 1);
    @(negedge clock_i);
    check("to_pulse_width", int'(timeout_o), 0);

    // Test 5: done on the very cycle the watchdog would expire.
    req_i = 3'b010;
    exp_q.push_back(1);
    wait_grant(1, "col");
    repeat (TO - 1) @(negedge clock_i);
    check("col_still_held", int'(grant_valid_o), 1);
    txn_done_i = 1'b1;
    req_i = '0;
    @(negedge clock_i);
    txn_done_i = 1'b0;
    check("col_released", int'(grant_valid_o), 0);
    check("col_no_timeout", int'(timeout_o), 0);
    check("col_cnt_same", int'(timeout_cnt_o), 1);

    // Done outside GRANT is ignored.
    txn_done_i = 1'b1;
    repeat (2) @(negedge clock_i);
    txn_done_i = 1'b0;
    check("stray_done_no_grant", int'(grant_valid_o), 0);
    check("stray_done_cnt", int'(timeout_cnt_o), 1);

    // Test 6: reset mid-grant clears outputs asynchronously.
    req_i = 3'b010;
    exp_q.push_back(1);
    wait_grant(1, "mid");
    repeat (3) @(negedge clock_i);
    #2 reset_ni = 1'b0;
    #1;
    check("arst_valid", int'(grant_valid_o), 0);
    check("arst_grant", int'(grant_o), 0);
    check("arst_idx", int'(grant_idx_o), 0);
    check("arst_tcnt", int'(timeout_cnt_o), 0);
    @(negedge clock_i);
    req_i = 3'b001;
    reset_ni = 1'b1;
    exp_q.push_back(0);
    wait_grant(1, "post_rst");
    release_txn(1, "post_rst");
    req_i = '0;
    repeat (3) @(negedge clock_i);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
